field_damper: RTL and testbench



---
 rtl/field_damper_pkg.sv | 46 ++++
 rtl/field_damper_if.sv | 31 +++
 rtl/field_damper_cell_update.sv | 36 +++
 rtl/field_damper.sv | 156 +++++++++++++++
 tb/tb_field_damper.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/field_damper_pkg.sv
// fluid_pkg: shared constants, cell/impulse types and the sweep FSM state
// encoding for the velocity-field update stage (field_damper).
package fluid_pkg;

  localparam int FIELD_WIDTH  = 80;
  localparam int FIELD_HEIGHT = 60;
  localparam int FIELD_SIZE   = FIELD_WIDTH * FIELD_HEIGHT;
  localparam int FIELD_ADDRW  = 13;
  localparam int FIELD_DATAW  = 96;

  // Q16.16 fixed point: directions are signed, magnitudes unsigned.
  typedef logic signed [31:0] q16_16_s_t;
  typedef logic        [31:0] q16_16_u_t;

  // One BRAM word: [95:64] xn, [63:32] yn, [31:0] mag.
  typedef struct packed {
    q16_16_s_t xn;
    q16_16_s_t yn;
    q16_16_u_t mag;
  } field_cell_t;

  // Impulse request as latched at sweep start.
  typedef struct packed {
    logic      valid;
    logic [6:0] x;
    logic [5:0] y;
    q16_16_s_t xn;
    q16_16_s_t yn;
    q16_16_u_t mag;
  } impulse_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SWEEP,
    ST_DRAIN,
    ST_FINISH
  } damper_state_t;

  // Unsigned add that clamps at all-ones instead of wrapping.
  function automatic q16_16_u_t sat_add_u32(input q16_16_u_t a, input q16_16_u_t b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/field_damper_if.sv
// field_damper_if: sweep control, impulse request and BRAM port bundle.
// master = controller/BRAM side, slave = field_damper.
interface field_damper_if;
  import fluid_pkg::*;

  logic                   start;
  logic                   busy;
  logic                   done;
  logic                   inj_valid;
  logic [6:0]             inj_x;
  logic [5:0]             inj_y;
  logic [31:0]            inj_xn;
  logic [31:0]            inj_yn;
  logic [31:0]            inj_mag;
  logic [FIELD_ADDRW-1:0] field_addr_read;
  logic [FIELD_DATAW-1:0] field_data_out;
  logic [FIELD_ADDRW-1:0] field_addr_write;
  logic [FIELD_DATAW-1:0] field_data_in;
  logic                   field_we;

  modport master (
    output start, inj_valid, inj_x, inj_y, inj_xn, inj_yn, inj_mag, field_data_out,
    input  busy, done, field_addr_read, field_addr_write, field_data_in, field_we
  );

  modport slave (
    input  start, inj_valid, inj_x, inj_y, inj_xn, inj_yn, inj_mag, field_data_out,
    output busy, done, field_addr_read, field_addr_write, field_data_in, field_we
  );

endinterface

// File: rtl/field_damper_cell_update.sv
// field_cell_update: combinational per-cell update. Damps the magnitude,
// zeroes cells that fall below MAG_MIN, then overlays the impulse if this
// cell is the impulse target.
module field_cell_update
  import fluid_pkg::*;
#(
  parameter int unsigned DAMP_SHIFT = 4,
  parameter logic [31:0] MAG_MIN    = 32'h0000_0100
) (
  input  field_cell_t cell_i,
  input  logic [6:0]  col_i,
  input  logic [5:0]  row_i,
  input  impulse_t    imp_i,
  output field_cell_t cell_o
);

  q16_16_u_t damped;
  logic      hit;

  // Damping first, impulse second, so an impulse always lands at full strength.
  always_comb begin
    cell_o     = cell_i;
    damped     = cell_i.mag - (cell_i.mag >> DAMP_SHIFT);
    cell_o.mag = damped;
    if (damped < MAG_MIN) begin
      cell_o = '0;
    end
    hit = imp_i.valid && (col_i == imp_i.x) && (row_i == imp_i.y);
    if (hit) begin
      cell_o.xn  = imp_i.xn;
      cell_o.yn  = imp_i.yn;
      cell_o.mag = sat_add_u32(cell_o.mag, imp_i.mag);
    end
  end

endmodule

// File: rtl/field_damper.sv
// field_damper: per-frame read-modify-write sweep over the velocity field.
// Read at t, update registered at t+1, write at t+2; one cell per cycle.
// Optional macro FIELD_DAMPER_STATS_EN adds the active_cells output.
module field_damper
  import fluid_pkg::*;
#(
  parameter int unsigned DAMP_SHIFT = 4,
  parameter logic [31:0] MAG_MIN    = 32'h0000_0100
) (
  input  logic               clk,
  input  logic               rst_n,
  field_damper_if.slave      bus
`ifdef FIELD_DAMPER_STATS_EN
  ,
  output logic [12:0]        active_cells
`endif
);

  localparam logic [FIELD_ADDRW-1:0] LAST_ADDR = FIELD_ADDRW'(FIELD_SIZE - 1);
  localparam logic [6:0]             LAST_COL  = 7'(FIELD_WIDTH - 1);

  damper_state_t          state_q, state_d;
  logic [FIELD_ADDRW-1:0] rd_addr_q, rd_addr_d;
  logic [6:0]             col_q, col_d;
  logic [5:0]             row_q, row_d;
  impulse_t               imp_q, imp_d;

  // Stage 1 tracks the cell whose data is on field_data_out this cycle.
  logic                   v1_q;
  logic [FIELD_ADDRW-1:0] addr1_q;
  logic [6:0]             col1_q;
  logic [5:0]             row1_q;

  // Stage 2 is the write port.
  logic                   we_q;
  logic [FIELD_ADDRW-1:0] waddr_q;
  field_cell_t            wdata_q;
  field_cell_t            upd_cell;

  field_cell_update #(
    .DAMP_SHIFT (DAMP_SHIFT),
    .MAG_MIN    (MAG_MIN)
  ) u_cell_update (
    .cell_i (field_cell_t'(bus.field_data_out)),
    .col_i  (col1_q),
    .row_i  (row1_q),
    .imp_i  (imp_q),
    .cell_o (upd_cell)
  );

  assign bus.busy             = (state_q == ST_SWEEP) || (state_q == ST_DRAIN);
  assign bus.done             = (state_q == ST_FINISH);
  assign bus.field_addr_read  = rd_addr_q;
  assign bus.field_addr_write = waddr_q;
  assign bus.field_data_in    = wdata_q;
  assign bus.field_we         = we_q;

  // Next-state logic: address/col/row counters advance together during SWEEP.
  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    col_d     = col_q;
    row_d     = row_q;
    imp_d     = imp_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          imp_d     = '{valid: bus.inj_valid, x: bus.inj_x, y: bus.inj_y,
                        xn: bus.inj_xn, yn: bus.inj_yn, mag: bus.inj_mag};
          rd_addr_d = '0;
          col_d     = '0;
          row_d     = '0;
          state_d   = ST_SWEEP;
        end
      end
      ST_SWEEP: begin
        if (rd_addr_q == LAST_ADDR) begin
          rd_addr_d = '0;
          col_d     = '0;
          row_d     = '0;
          state_d   = ST_DRAIN;
        end else begin
          rd_addr_d = rd_addr_q + 1'b1;
          if (col_q == LAST_COL) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      // Leave once the final write is on the port and nothing is behind it.
      ST_DRAIN:  if (we_q && !v1_q) state_d = ST_FINISH;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State, counters and the two pipeline stages.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      rd_addr_q <= '0;
      col_q     <= '0;
      row_q     <= '0;
      imp_q     <= '0;
      v1_q      <= 1'b0;
      addr1_q   <= '0;
      col1_q    <= '0;
      row1_q    <= '0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      col_q     <= col_d;
      row_q     <= row_d;
      imp_q     <= imp_d;
      v1_q      <= (state_q == ST_SWEEP);
      addr1_q   <= rd_addr_q;
      col1_q    <= col_q;
      row1_q    <= row_q;
      we_q      <= v1_q;
      if (v1_q) begin
        waddr_q <= addr1_q;
        wdata_q <= upd_cell;
      end
    end
  end

`ifdef FIELD_DAMPER_STATS_EN
  logic [12:0] nz_cnt_q;
  logic [12:0] active_q;

  // Count non-zero written cells; publish the total as FINISH begins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nz_cnt_q <= '0;
      active_q <= '0;
    end else begin
      if (state_q == ST_IDLE && bus.start) begin
        nz_cnt_q <= '0;
      end else if (v1_q && (upd_cell.mag != '0)) begin
        nz_cnt_q <= nz_cnt_q + 1'b1;
      end
      if (state_q == ST_DRAIN && state_d == ST_FINISH) begin
        active_q <= nz_cnt_q;
      end
    end
  end

  assign active_cells = active_q;
`endif

endmodule

// File: tb/tb_field_damper.sv
// Scoreboard bench for field_damper: a behavioural BRAM holds the field,
// expected writes are queued at sweep issue and popped by a write monitor.
module tb_field_damper;
  import fluid_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  field_damper_if bus();
`ifdef FIELD_DAMPER_STATS_EN
  logic [12:0] active_cells;
`endif

  field_damper #(.DAMP_SHIFT(4), .MAG_MIN(32'h0000_0100)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef FIELD_DAMPER_STATS_EN
    ,
    .active_cells (active_cells)
`endif
  );

  typedef struct {
    int          addr;
    logic [95:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails = 0;
  int   writes_seen = 0;

  logic [95:0] mem [FIELD_SIZE];
  logic        init_go = 1'b0;
  int          init_mode = 0;

  function automatic logic [95:0] pattern(input int mode, input int i);
    logic [31:0] iv;
    iv = 32'(i);
    case (mode)
      0: return {32'h0001_0000, 32'hFFFF_0000, 32'h0001_0000};
      1: return (i == 5) ? {32'h0000_1234, 32'h0000_5678, 32'h0000_0108}
                         : {32'h0001_0000, 32'hFFFF_0000, 32'h0001_0000};
      2: return {32'h0003_0000, 32'h0004_0000, 32'h0010_0000};
      default: return {iv, ~iv, iv * 32'h0000_0061};
    endcase
  endfunction

  // Behavioural BRAM: registered read, write port driven by the DUT.
  always @(posedge clk) begin
    if (init_go) begin
      for (int i = 0; i < FIELD_SIZE; i++) mem[i] <= pattern(init_mode, i);
    end else if (bus.field_we) begin
      mem[bus.field_addr_write] <= bus.field_data_in;
    end
    bus.field_data_out <= mem[bus.field_addr_read];
  end

  function automatic logic [95:0] model(input logic [95:0] c, input int col, input int row,
                                        input logic iv, input int ix, input int iy,
                                        input logic [31:0] ixn, input logic [31:0] iyn,
                                        input logic [31:0] imag);
    logic [31:0] m, xn, yn;
    logic [32:0] s;
    xn = c[95:64];
    yn = c[63:32];
    m  = c[31:0] - (c[31:0] >> 4);
    if (m < 32'h0000_0100) begin
      m = 0; xn = 0; yn = 0;
    end
    if (iv && col == ix && row == iy) begin
      xn = ixn;
      yn = iyn;
      s  = {1'b0, m} + {1'b0, imag};
      m  = s[32] ? 32'hFFFF_FFFF : s[31:0];
    end
    return {xn, yn, m};
  endfunction

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Write monitor: every write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && bus.field_we) begin
      writes_seen++;
      checks++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write actual addr=%0d required none", bus.field_addr_write);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (int'(bus.field_addr_write) != e.addr || bus.field_data_in !== e.data) begin
          fails++;
          $display("FAIL write actual addr=%0d data=%h required addr=%0d data=%h",
                   bus.field_addr_write, bus.field_data_in, e.addr, e.data);
        end
      end
    end
  end

  task automatic init_mem(input int mode);
    init_mode = mode;
    init_go   = 1'b1;
    @(posedge clk); #1;
    init_go   = 1'b0;
  endtask

  function automatic logic [63:0] checksum();
    logic [63:0] cs;
    cs = 0;
    for (int a = 0; a < FIELD_SIZE; a++)
      cs = cs * 64'd31 + {32'b0, mem[a][95:64]} + {32'b0, mem[a][63:32]} + {32'b0, mem[a][31:0]};
    return cs;
  endfunction

  task automatic sweep(input logic iv, input logic [6:0] ix, input logic [5:0] iy,
                       input logic [31:0] ixn, input logic [31:0] iyn, input logic [31:0] imag,
                       input int restart_at, input int reset_at);
    int   cnt, exp_nz, w0;
    exp_t e;
    exp_nz = 0;
    for (int a = 0; a < FIELD_SIZE; a++) begin
      e.addr = a;
      e.data = model(mem[a], a % FIELD_WIDTH, a / FIELD_WIDTH, iv, int'(ix), int'(iy), ixn, iyn, imag);
      if (e.data[31:0] != 0) exp_nz++;
      sb.push_back(e);
    end
    w0 = writes_seen;
    bus.start = 1'b1;
    bus.inj_valid = iv; bus.inj_x = ix; bus.inj_y = iy;
    bus.inj_xn = ixn; bus.inj_yn = iyn; bus.inj_mag = imag;
    @(posedge clk); #1;
    // Change impulse inputs after acceptance: the latched copy must be used.
    bus.start = 1'b0;
    bus.inj_valid = ~iv; bus.inj_x = 7'd0; bus.inj_y = 6'd0;
    bus.inj_xn = 32'hDEAD_0000; bus.inj_yn = 32'hBEEF_0000; bus.inj_mag = 32'h0000_1234;
    cnt = 1;
    check("busy_in_sweep", {95'b0, bus.busy}, 96'd1);
    while (bus.done !== 1'b1 && cnt < 6000) begin
      if (cnt == reset_at) begin
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("reset_busy", {95'b0, bus.busy}, 96'd0);
        check("reset_we", {95'b0, bus.field_we}, 96'd0);
        check("reset_raddr", {83'b0, bus.field_addr_read}, 96'd0);
        rst_n = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        check("idle_after_reset", {95'b0, bus.busy}, 96'd0);
        return;
      end
      if (cnt == restart_at) bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      cnt++;
    end
    check("done_latency", 96'(cnt), 96'd4803);
    check("write_count", 96'(writes_seen - w0), 96'd4800);
    check("scoreboard_empty", 96'(sb.size()), 96'd0);
`ifdef FIELD_DAMPER_STATS_EN
    check("active_cells", {83'b0, active_cells}, 96'(exp_nz));
`endif
    @(posedge clk); #1;
    check("done_single_pulse", {95'b0, bus.done}, 96'd0);
    check("busy_after_done", {95'b0, bus.busy}, 96'd0);
    sb.delete();
  endtask

  logic [63:0] cs_a, cs_b;

  initial begin
    bus.start = 1'b0; bus.inj_valid = 1'b0; bus.inj_x = '0; bus.inj_y = '0;
    bus.inj_xn = '0; bus.inj_yn = '0; bus.inj_mag = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {95'b0, bus.busy}, 96'd0);
    check("rst_done", {95'b0, bus.done}, 96'd0);
    check("rst_we", {95'b0, bus.field_we}, 96'd0);
    check("rst_raddr", {83'b0, bus.field_addr_read}, 96'd0);
    check("rst_waddr", {83'b0, bus.field_addr_write}, 96'd0);
    check("rst_wdata", bus.field_data_in, 96'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Uniform field, damping only.
    init_mem(0);
    sweep(1'b0, 7'd0, 6'd0, 32'd0, 32'd0, 32'd0, -1, -1);
    check("t1_cell0", mem[0], {32'h0001_0000, 32'hFFFF_0000, 32'h0000_F000});
    check("t1_cell4799", mem[4799], {32'h0001_0000, 32'hFFFF_0000, 32'h0000_F000});

    // A cell that falls below MAG_MIN is zeroed entirely.
    init_mem(1);
    sweep(1'b0, 7'd0, 6'd0, 32'd0, 32'd0, 32'd0, -1, -1);
    check("t2_zeroed", mem[5], 96'd0);
    check("t2_neighbour", mem[6], {32'h0001_0000, 32'hFFFF_0000, 32'h0000_F000});

    // Impulse at the last cell saturates the magnitude.
    init_mem(2);
    sweep(1'b1, 7'd79, 6'd59, 32'h0007_0000, 32'hFFF9_0000, 32'hFFFF_0000, -1, -1);
    check("t3_impulse", mem[4799], {32'h0007_0000, 32'hFFF9_0000, 32'hFFFF_FFFF});
    check("t3_other", mem[4798], {32'h0003_0000, 32'h0004_0000, 32'h000F_0000});
    check("t3_first", mem[0], {32'h0003_0000, 32'h0004_0000, 32'h000F_0000});

    // Out-of-range impulse column matches nothing.
    init_mem(3);
    sweep(1'b0, 7'd0, 6'd0, 32'd0, 32'd0, 32'd0, -1, -1);
    cs_a = checksum();
    check("t4_small_zero", mem[1], 96'd0);
    check("t4_cell3", mem[3], {32'h0000_0003, 32'hFFFF_FFFC, 32'h0000_0111});
    init_mem(3);
    sweep(1'b1, 7'd80, 6'd10, 32'h0005_0000, 32'h0006_0000, 32'h0000_5555, -1, -1);
    cs_b = checksum();
    check("t4_checksum", {32'b0, cs_b}, {32'b0, cs_a});

    // start mid-sweep is ignored.
    init_mem(0);
    sweep(1'b0, 7'd0, 6'd0, 32'd0, 32'd0, 32'd0, 100, -1);

    // Reset at cycle 1000, then a full sweep over the partially updated field.
    init_mem(0);
    sweep(1'b0, 7'd0, 6'd0, 32'd0, 32'd0, 32'd0, -1, 1000);
    sweep(1'b0, 7'd0, 6'd0, 32'd0, 32'd0, 32'd0, -1, -1);
    check("t6_twice_damped", mem[0], {32'h0001_0000, 32'hFFFF_0000, 32'h0000_E100});
    check("t6_once_damped", mem[4799], {32'h0001_0000, 32'hFFFF_0000, 32'h0000_F000});

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
